// File: rtl/osd_trace_pkg.sv
// Shared constants, FSM states and FLAGS-flit builder for the trace packetizer.
// OSD_TRACE_TIMESTAMP_EN, when defined, enables the TS_LO/TS_HI states.
package osd_trace_pkg;

  localparam logic [1:0] PKT_TYPE_EVENT    = 2'b10;
  localparam logic [3:0] TYPE_SUB_TRACE    = 4'd0;
  localparam logic [3:0] TYPE_SUB_OVERFLOW = 4'd1;

  localparam int FLAGS_TYPE_LSB     = 14;
  localparam int FLAGS_TYPE_SUB_LSB = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DEST    = 3'd1,
    SRC     = 3'd2,
    FLAGS   = 3'd3,
    TS_LO   = 3'd4,
    TS_HI   = 3'd5,
    PAYLOAD = 3'd6
  } state_t;

  function automatic logic [15:0] make_flags(input logic overflow);
    logic [15:0] flags;
    flags = '0;
    flags[FLAGS_TYPE_LSB +: 2]     = PKT_TYPE_EVENT;
    flags[FLAGS_TYPE_SUB_LSB +: 4] = overflow ? TYPE_SUB_OVERFLOW : TYPE_SUB_TRACE;
    return flags;
  endfunction

endpackage

// File: rtl/osd_trace_packetize.sv
// Pops trace FIFO entries and serializes each into one debug event packet.
// OSD_TRACE_TIMESTAMP_EN adds a 32-bit cycle timestamp (TS_LO, TS_HI) after FLAGS.
module osd_trace_packetize
  import osd_trace_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      id,
  input  logic [15:0]      event_dest,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_overflow,
  input  logic             fifo_valid,
  output logic             fifo_ready,
  output logic [15:0]      dp_out_data,
  output logic             dp_out_last,
  output logic             dp_out_valid,
  input  logic             dp_out_ready
);

  localparam int NUM_PAYLOAD = (WIDTH + 15) / 16;
  localparam int CNT_W       = (NUM_PAYLOAD > 1) ? $clog2(NUM_PAYLOAD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PAYLOAD - 1);

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [WIDTH-1:0]   data_reg;
  logic               overflow_reg;
  logic               accept;

  assign accept = fifo_valid && (state_reg == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Entries are captured even when disabled; they are simply never sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg     <= '0;
      overflow_reg <= 1'b0;
    end else if (accept) begin
      data_reg     <= fifo_data;
      overflow_reg <= fifo_overflow;
    end
  end

`ifdef OSD_TRACE_TIMESTAMP_EN
  logic [31:0] ts_cnt_reg, ts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_reg <= '0;
      ts_reg     <= '0;
    end else begin
      ts_cnt_reg <= ts_cnt_reg + 32'd1;
      if (accept) ts_reg <= ts_cnt_reg;
    end
  end
`endif

  // Zero-extend the sample to whole flits, then slice it LSB-first.
  logic [NUM_PAYLOAD*16-1:0] data_padded;
  logic [15:0]               payload_flit [NUM_PAYLOAD];

  always_comb begin
    data_padded            = '0;
    data_padded[WIDTH-1:0] = data_reg;
  end

  for (genvar gi = 0; gi < NUM_PAYLOAD; gi++) begin : g_flit
    assign payload_flit[gi] = data_padded[gi*16 +: 16];
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    fifo_ready   = 1'b0;
    dp_out_valid = 1'b0;
    dp_out_last  = 1'b0;
    dp_out_data  = '0;
    case (state_reg)
      IDLE: begin
        fifo_ready = rst_n;
        cnt_next   = '0;
        if (fifo_valid && enable) state_next = DEST;
      end
      DEST: begin
        dp_out_valid = 1'b1;
        dp_out_data  = event_dest;
        if (dp_out_ready) state_next = SRC;
      end
      SRC: begin
        dp_out_valid = 1'b1;
        dp_out_data  = id;
        if (dp_out_ready) state_next = FLAGS;
      end
      FLAGS: begin
        dp_out_valid = 1'b1;
        dp_out_data  = make_flags(overflow_reg);
`ifdef OSD_TRACE_TIMESTAMP_EN
        if (dp_out_ready) state_next = TS_LO;
`else
        if (dp_out_ready) state_next = PAYLOAD;
`endif
      end
`ifdef OSD_TRACE_TIMESTAMP_EN
      TS_LO: begin
        dp_out_valid = 1'b1;
        dp_out_data  = ts_reg[15:0];
        if (dp_out_ready) state_next = TS_HI;
      end
      TS_HI: begin
        dp_out_valid = 1'b1;
        dp_out_data  = ts_reg[31:16];
        if (dp_out_ready) state_next = PAYLOAD;
      end
`endif
      PAYLOAD: begin
        dp_out_valid = 1'b1;
        dp_out_data  = overflow_reg ? data_reg[15:0] : payload_flit[cnt_reg];
        dp_out_last  = overflow_reg || (cnt_reg == CNT_LAST);
        if (dp_out_ready) begin
          if (dp_out_last) state_next = IDLE;
          else             cnt_next   = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_osd_trace_packetize.sv
// Directed bench: a WIDTH=16 instance (a_*) and a WIDTH=40 instance (b_*) side by side.
module tb_osd_trace_packetize;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] id, event_dest;
  logic        enable, dp_out_ready;

  logic [15:0] a_fifo_data;
  logic        a_fifo_overflow, a_fifo_valid, a_fifo_ready;
  logic [15:0] a_data;
  logic        a_last, a_valid;

  logic [39:0] b_fifo_data;
  logic        b_fifo_overflow, b_fifo_valid, b_fifo_ready;
  logic [15:0] b_data;
  logic        b_last, b_valid;

  int n_checks = 0;
  int n_errors = 0;
  bit sel = 1'b0;

  logic [15:0] o_data;
  logic        o_last, o_valid, o_fifo_ready;
  assign o_data       = sel ? b_data       : a_data;
  assign o_last       = sel ? b_last       : a_last;
  assign o_valid      = sel ? b_valid      : a_valid;
  assign o_fifo_ready = sel ? b_fifo_ready : a_fifo_ready;

  always #5 clk = ~clk;

  osd_trace_packetize #(.WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .id(id), .event_dest(event_dest), .enable(enable),
    .fifo_data(a_fifo_data), .fifo_overflow(a_fifo_overflow), .fifo_valid(a_fifo_valid),
    .fifo_ready(a_fifo_ready), .dp_out_data(a_data), .dp_out_last(a_last),
    .dp_out_valid(a_valid), .dp_out_ready(dp_out_ready)
  );

  osd_trace_packetize #(.WIDTH(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .id(id), .event_dest(event_dest), .enable(enable),
    .fifo_data(b_fifo_data), .fifo_overflow(b_fifo_overflow), .fifo_valid(b_fifo_valid),
    .fifo_ready(b_fifo_ready), .dp_out_data(b_data), .dp_out_last(b_last),
    .dp_out_valid(b_valid), .dp_out_ready(dp_out_ready)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one entry for one cycle; the DUT must be ready for it.
  task automatic send(input bit s, input logic [39:0] d, input logic ovf, input string tag);
    sel = s;
    if (s) begin
      b_fifo_data = d; b_fifo_overflow = ovf; b_fifo_valid = 1'b1;
    end else begin
      a_fifo_data = d[15:0]; a_fifo_overflow = ovf; a_fifo_valid = 1'b1;
    end
    #1;
    check({tag, ".fifo_ready"}, o_fifo_ready, 1'b1);
    $display("send %s: data=0x%0h ovf=%0b", tag, d, ovf);
    step();
    a_fifo_valid = 1'b0;
    b_fifo_valid = 1'b0;
  endtask

  task automatic expect_flit(input logic [15:0] exp, input logic exp_last, input string tag);
    check({tag, ".valid"}, o_valid, 1'b1);
    check({tag, ".data"},  o_data,  exp);
    check({tag, ".last"},  o_last,  exp_last);
    $display("flit %s: data=0x%04h last=%0b", tag, o_data, o_last);
    step();
  endtask

  task automatic expect_idle(input string tag);
    check({tag, ".idle_valid"}, o_valid, 1'b0);
    check({tag, ".idle_ready"}, o_fifo_ready, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; id = 16'h0005; event_dest = 16'h0000; enable = 1'b1; dp_out_ready = 1'b1;
    a_fifo_data = '0; a_fifo_overflow = 1'b0; a_fifo_valid = 1'b0;
    b_fifo_data = '0; b_fifo_overflow = 1'b0; b_fifo_valid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.a_valid", a_valid, 1'b0);
    check("rst.a_data", a_data, 16'h0000);
    check("rst.a_last", a_last, 1'b0);
    check("rst.a_fifo_ready", a_fifo_ready, 1'b0);
    check("rst.b_fifo_ready", b_fifo_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    check("rst.a_ready_after", a_fifo_ready, 1'b1);
    step();

    // Single-flit trace sample
    send(0, 40'hABCD, 1'b0, "t1");
    expect_flit(16'h0000, 1'b0, "t1.dest");
    expect_flit(16'h0005, 1'b0, "t1.src");
    expect_flit(16'h8000, 1'b0, "t1.flags");
    expect_flit(16'hABCD, 1'b1, "t1.pay");
    expect_idle("t1");

    // Overflow record
    send(0, 40'h0003, 1'b1, "t2");
    expect_flit(16'h0000, 1'b0, "t2.dest");
    expect_flit(16'h0005, 1'b0, "t2.src");
    expect_flit(16'h8400, 1'b0, "t2.flags");
    expect_flit(16'h0003, 1'b1, "t2.pay");
    expect_idle("t2");

    // Multi-flit sample, WIDTH=40
    send(1, 40'h123456789A, 1'b0, "t3");
    expect_flit(16'h0000, 1'b0, "t3.dest");
    expect_flit(16'h0005, 1'b0, "t3.src");
    expect_flit(16'h8000, 1'b0, "t3.flags");
    expect_flit(16'h789A, 1'b0, "t3.pay0");
    expect_flit(16'h3456, 1'b0, "t3.pay1");
    expect_flit(16'h0012, 1'b1, "t3.pay2");
    expect_idle("t3");

    // Overflow on WIDTH=40: upper bits ignored, single payload flit
    send(1, 40'hFFFFFF0003, 1'b1, "t4");
    expect_flit(16'h0000, 1'b0, "t4.dest");
    expect_flit(16'h0005, 1'b0, "t4.src");
    expect_flit(16'h8400, 1'b0, "t4.flags");
    expect_flit(16'h0003, 1'b1, "t4.pay");
    expect_idle("t4");

    // Backpressure during SRC
    send(0, 40'h1111, 1'b0, "t5");
    expect_flit(16'h0000, 1'b0, "t5.dest");
    dp_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5.hold_valid", o_valid, 1'b1);
      check("t5.hold_data", o_data, 16'h0005);
      check("t5.hold_last", o_last, 1'b0);
      check("t5.hold_fifo_ready", o_fifo_ready, 1'b0);
      $display("hold t5 cycle %0d: data=0x%04h", i, o_data);
      step();
    end
    dp_out_ready = 1'b1;
    expect_flit(16'h0005, 1'b0, "t5.src");
    expect_flit(16'h8000, 1'b0, "t5.flags");
    expect_flit(16'h1111, 1'b1, "t5.pay");
    expect_idle("t5");

    // Disabled: drain 4 entries, no output
    enable = 1'b0;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_fifo_data = 16'(16'h0100 + i); a_fifo_overflow = 1'b0; a_fifo_valid = 1'b1;
      #1;
      check("t6.fifo_ready", a_fifo_ready, 1'b1);
      check("t6.valid", a_valid, 1'b0);
      $display("drain t6 entry %0d: data=0x%04h", i, a_fifo_data);
      step();
    end
    a_fifo_valid = 1'b0;
    #1;
    check("t6.after_valid", a_valid, 1'b0);
    check("t6.after_ready", a_fifo_ready, 1'b1);
    enable = 1'b1;

    // Enable dropped mid-packet: packet still completes
    send(0, 40'h5A5A, 1'b0, "t7");
    expect_flit(16'h0000, 1'b0, "t7.dest");
    enable = 1'b0;
    expect_flit(16'h0005, 1'b0, "t7.src");
    expect_flit(16'h8000, 1'b0, "t7.flags");
    expect_flit(16'h5A5A, 1'b1, "t7.pay");
    expect_idle("t7");
    enable = 1'b1;

    // Reset asserted in FLAGS
    send(0, 40'h2222, 1'b0, "t8");
    expect_flit(16'h0000, 1'b0, "t8.dest");
    expect_flit(16'h0005, 1'b0, "t8.src");
    check("t8.flags_data", o_data, 16'h8000);
    #2 rst_n = 1'b0;
    #1;
    check("t8.rst_valid", a_valid, 1'b0);
    check("t8.rst_data", a_data, 16'h0000);
    check("t8.rst_fifo_ready", a_fifo_ready, 1'b0);
    $display("reset t8: valid=%0b", a_valid);
    step();
    rst_n = 1'b1;
    #1;
    expect_idle("t8.post");
    send(0, 40'h3333, 1'b0, "t9");
    expect_flit(16'h0000, 1'b0, "t9.dest");
    expect_flit(16'h0005, 1'b0, "t9.src");
    expect_flit(16'h8000, 1'b0, "t9.flags");
    expect_flit(16'h3333, 1'b1, "t9.pay");
    expect_idle("t9");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
